// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding and hazard controller.
package fwd_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } dest_tag_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward select: picks the newest in-flight producer of rs, never x0.
module fwd_select
    import fwd_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  uses,
    input  dest_tag_t             mem_tag,
    input  dest_tag_t             wb_tag,
    output logic [1:0]            sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = uses & mem_tag.valid & mem_tag.reg_write &
                     (mem_tag.rd != '0) & (mem_tag.rd == rs);
    assign wb_hit  = uses & wb_tag.valid & wb_tag.reg_write &
                     (wb_tag.rd != '0) & (wb_tag.rd == rs);

    // MEM holds the younger write, so it shadows a matching WB entry.
    always_comb begin
        sel = FWD_ID;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forwarding_hazard_ctrl.sv
// EX forwarding mux control, load-use stall, branch flush and memory-stall freeze,
// with a shadow pipeline of destination tags and saturating event counters.
module forwarding_hazard_ctrl #(
    parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic                  freeze,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
);

    import fwd_pkg::*;

    dest_tag_t             ex_tag;
    dest_tag_t             mem_tag;
    dest_tag_t             wb_tag;
    dest_tag_t             id_tag;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  ex_uses1;
    logic                  ex_uses2;
    logic                  load_use;
    logic                  fwd_any;

    fwd_select u_fwd_a (
        .rs      (ex_rs1),
        .uses    (ex_uses1),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (fwd_a_sel)
    );

    fwd_select u_fwd_b (
        .rs      (ex_rs2),
        .uses    (ex_uses2),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (fwd_b_sel)
    );

    // An empty ID slot enters EX with all destination fields cleared.
    always_comb begin
        id_tag           = '0;
        id_tag.valid     = id_valid;
        id_tag.rd        = id_valid ? id_rd : '0;
        id_tag.reg_write = id_valid & id_reg_write;
        id_tag.mem_read  = id_valid & id_mem_read;
    end

    assign load_use = id_valid & ex_tag.valid & ex_tag.mem_read & (ex_tag.rd != '0) &
                      (((ex_tag.rd == id_rs1) & id_uses_rs1) |
                       ((ex_tag.rd == id_rs2) & id_uses_rs2));

    // A taken branch squashes the stalled consumer, so flush outranks load-use.
    assign freeze      = mem_stall;
    assign flush_if_id = ~mem_stall & ex_branch_taken;
    assign stall_if_id = ~mem_stall & ~ex_branch_taken & load_use;
    assign bubble_ex   = ~mem_stall & (ex_branch_taken | load_use);
    assign fwd_any     = (fwd_a_sel != FWD_ID) | (fwd_b_sel != FWD_ID);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag    <= '0;
            mem_tag   <= '0;
            wb_tag    <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_uses1  <= 1'b0;
            ex_uses2  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!mem_stall) begin
            wb_tag   <= mem_tag;
            mem_tag  <= ex_tag;
            ex_tag   <= bubble_ex ? '0 : id_tag;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_uses1 <= id_uses_rs1 & ~bubble_ex;
            ex_uses2 <= id_uses_rs2 & ~bubble_ex;
            if (stall_if_id && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_if_id && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (fwd_any && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// Directed-vector bench for forwarding_hazard_ctrl with a queue-based scoreboard.
module tb_forwarding_hazard_ctrl;

    localparam int OW = 104;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        ex_branch_taken;
    logic        mem_stall;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall_if_id;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        freeze;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] fwd_cnt;

    logic [OW-1:0] exp_q[$];
    string         lbl_q[$];
    logic          chk_q[$];
    int            vectors;
    int            miscompares;

    forwarding_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .freeze          (freeze),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .fwd_cnt         (fwd_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // instruction builders
    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t alu(input int rd, input int rs1, input int rs2);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
        i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t ld(input int rd, input int rs1);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.u1 = 1'b1;
        i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic logic [OW-1:0] ex(input int a, input int b, input int st, input int bu,
                                         input int fl, input int fz, input int sc, input int fc,
                                         input int wc);
        return {2'(a), 2'(b), 1'(st), 1'(bu), 1'(fl), 1'(fz), 32'(sc), 32'(fc), 32'(wc)};
    endfunction

    function automatic string fmt(input logic [OW-1:0] o);
        return $sformatf("a=%0d b=%0d st=%0d bu=%0d fl=%0d fz=%0d sc=%0d fc=%0d wc=%0d",
                         o[103:102], o[101:100], o[99], o[98], o[97], o[96],
                         o[95:64], o[63:32], o[31:0]);
    endfunction

    // driver tasks
    task automatic drive(input logic r, input instr_t i, input logic br, input logic ms);
        rst             = r;
        id_valid        = i.v;
        id_rs1          = i.rs1;
        id_rs2          = i.rs2;
        id_uses_rs1     = i.u1;
        id_uses_rs2     = i.u2;
        id_rd           = i.rd;
        id_reg_write    = i.rw;
        id_mem_read     = i.mr;
        ex_branch_taken = br;
        mem_stall       = ms;
    endtask

    task automatic step(input string lbl, input instr_t i, input logic br, input logic ms,
                        input logic [OW-1:0] e);
        @(posedge clk);
        #1;
        drive(1'b0, i, br, ms);
        exp_q.push_back(e);
        lbl_q.push_back(lbl);
        chk_q.push_back(1'b1);
    endtask

    task automatic rst_step(input instr_t i, input logic ms);
        @(posedge clk);
        #1;
        drive(1'b1, i, 1'b0, ms);
        exp_q.push_back('0);
        lbl_q.push_back("reset");
        chk_q.push_back(1'b0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [OW-1:0] got;
        logic [OW-1:0] e;
        string         l;
        logic          c;
        got = {fwd_a_sel, fwd_b_sel, stall_if_id, bubble_ex, flush_if_id, freeze,
               stall_cnt, flush_cnt, fwd_cnt};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            c = chk_q.pop_front();
            if (c) begin
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL %s: got %s required %s", l, fmt(got), fmt(e));
                end
            end
        end
        if (!rst && ((fwd_a_sel == 2'b11) || (fwd_b_sel == 2'b11))) begin
            miscompares++;
            $display("FAIL sel_11: got a=%0d b=%0d required neither 3", fwd_a_sel, fwd_b_sel);
        end
        if (!rst && dut.mem_tag.mem_read && ((fwd_a_sel == 2'b01) || (fwd_b_sel == 2'b01))) begin
            miscompares++;
            $display("FAIL mem_fwd_of_load: got a=%0d b=%0d required no 1 while MEM is a load",
                     fwd_a_sel, fwd_b_sel);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        drive(1'b1, nop(), 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        // back-to-back ALU forward from MEM
        rst_step(nop(), 1'b0);
        step("t1_reset",    nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t1_add",      alu(5, 1, 2),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t1_sub_id",   alu(6, 5, 1),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t1_sub_ex",   nop(),          0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t1_cnt",      nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // producer two ahead forwards from WB
        rst_step(nop(), 1'b0);
        step("t2_add",      alu(5, 1, 2),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t2_nop",      nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t2_or_id",    alu(7, 1, 5),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t2_or_ex",    nop(),          0, 0, ex(0, 2, 0, 0, 0, 0, 0, 0, 0));
        step("t2_cnt",      nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // MEM and WB both match: MEM wins
        rst_step(nop(), 1'b0);
        step("t3_add1",     alu(5, 1, 2),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t3_add2",     alu(5, 1, 2),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t3_use_id",   alu(4, 5, 3),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t3_use_ex",   nop(),          0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t3_cnt",      nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // load-use: one stall cycle, then forward from WB
        rst_step(nop(), 1'b0);
        step("t4_lw",       ld(8, 1),       0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t4_stall",    alu(9, 8, 8),   0, 0, ex(0, 0, 1, 1, 0, 0, 0, 0, 0));
        step("t4_held",     alu(9, 8, 8),   0, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0));
        step("t4_add_ex",   nop(),          0, 0, ex(2, 2, 0, 0, 0, 0, 1, 0, 0));
        step("t4_cnt",      nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 1));

        // branch taken overrides a pending load-use
        rst_step(nop(), 1'b0);
        step("t5_lw",       ld(8, 1),       0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t5_flush",    alu(9, 8, 8),   1, 0, ex(0, 0, 0, 1, 1, 0, 0, 0, 0));
        step("t5_cnt",      nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        step("t5_after",    nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));

        // x0 never forwards and never stalls
        rst_step(nop(), 1'b0);
        step("t6_add_x0",   alu(0, 1, 2),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t6_use_x0",   alu(3, 0, 0),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t6_lw_x0",    ld(0, 1),       0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t6_ld_use",   alu(3, 0, 0),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t6_drain1",   nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t6_drain2",   nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // memory stall freezes a forwarding pair; branch is masked while frozen
        rst_step(nop(), 1'b0);
        step("t7_add",      alu(5, 1, 2),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t7_sub_id",   alu(6, 5, 1),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t7_frz1",     nop(),          0, 1, ex(1, 0, 0, 0, 0, 1, 0, 0, 0));
        step("t7_frz2_br",  nop(),          1, 1, ex(1, 0, 0, 0, 0, 1, 0, 0, 0));
        step("t7_frz3",     nop(),          0, 1, ex(1, 0, 0, 0, 0, 1, 0, 0, 0));
        step("t7_thaw",     nop(),          0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t7_cnt",      nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("t7_lw",       ld(8, 1),       0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("t7_frz_ldu",  alu(9, 8, 8),   0, 1, ex(0, 0, 0, 0, 0, 1, 0, 0, 1));
        rst_step(alu(9, 8, 8), 1'b1);
        step("t7_post_rst", alu(9, 8, 8),   0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("t7_drain",    nop(),          0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));

        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                miscompares++;
                $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
